reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump_pkg.sv | 41 ++++
 rtl/uart_byte_tx.sv | 99 +++++++++
 rtl/reg_dump.sv | 93 +++++++++
 tb/tb_reg_dump.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared definitions for the register dump block.
// The PAR state and the 11-bit frame length apply only when
// REG_DUMP_PARITY_EN is defined.
package reg_dump_pkg;

  localparam int BYTE_W         = 8;
  localparam int FRAME_BITS     = 10;
  localparam int FRAME_BITS_PAR = 11;

`ifdef REG_DUMP_PARITY_EN
  localparam int FRAME_LEN = FRAME_BITS_PAR;
`else
  localparam int FRAME_LEN = FRAME_BITS;
`endif

  // Bit-level frame states. LOAD is the sequencer's register-fetch cycle,
  // during which the byte transmitter sits in IDLE with the line high.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
`ifdef REG_DUMP_PARITY_EN
    PAR,
`endif
    STOP
  } state_t;

  // Register/byte sequencer states.
  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_LOW,
    SEQ_HIGH
  } seq_t;

  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: sends one 8-bit frame (start, 8 data bits LSB first,
// optional even parity when REG_DUMP_PARITY_EN is defined, stop).
// A load strobe starts a frame; the byte is captured at the end of the
// start bit, so the caller only needs byte_in stable by then. A load on
// the last stop cycle chains the next frame with no idle gap.
module uart_byte_tx
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              tx,
  output logic              byte_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shifter;
  logic              bit_end;
`ifdef REG_DUMP_PARITY_EN
  logic              parity_bit;
`endif

  assign bit_end = (cnt == CNT_MAX);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: each bit lasts CLKS_PER_BIT cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (load) state_next = START;
      START: if (bit_end) state_next = DATA;
`ifdef REG_DUMP_PARITY_EN
      DATA:  if (bit_end && bit_idx == 3'd7) state_next = PAR;
      PAR:   if (bit_end) state_next = STOP;
`else
      DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
`endif
      STOP:  if (bit_end) state_next = load ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shifter    <= '0;
`ifdef REG_DUMP_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      if (state == START && bit_end) begin
        shifter    <= byte_in;
`ifdef REG_DUMP_PARITY_EN
        parity_bit <= even_parity(byte_in);
`endif
      end else if (state == DATA && bit_end) begin
        shifter <= shifter >> 1;
      end
      if (state == DATA) begin
        if (bit_end) bit_idx <= bit_idx + 1'b1;
      end else begin
        bit_idx <= '0;
      end
    end
  end

  // Line level and end-of-frame strobe.
  always_comb begin
    tx        = 1'b1;
    byte_done = 1'b0;
    case (state)
      START: tx = 1'b0;
      DATA:  tx = shifter[0];
`ifdef REG_DUMP_PARITY_EN
      PAR:   tx = parity_bit;
`endif
      STOP:  byte_done = bit_end;
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_dump.sv
// reg_dump: on start, reads registers FIRST_REG..LAST_REG and sends each
// one as two serial frames (low byte, then high byte).
// Define REG_DUMP_PARITY_EN to add an even-parity bit to every frame.
// Only DATA_W = 16 is supported.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int FIRST_REG    = 1,
  parameter int LAST_REG     = 5,
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(LAST_REG);

  seq_t              seq;
  seq_t              seq_next;
  logic [DATA_W-1:0] hold;
  logic              byte_load;
  logic [BYTE_W-1:0] byte_sel;
  logic              byte_done;
  logic              last_reg;

  assign last_reg = (rf_addr == ADDR_LAST);

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) seq <= SEQ_IDLE;
    else        seq <= seq_next;
  end

  // Sequencer next state: fetch, low frame, high frame, then next register or idle.
  always_comb begin
    seq_next = seq;
    case (seq)
      SEQ_IDLE: if (start) seq_next = SEQ_LOAD;
      SEQ_LOAD: seq_next = SEQ_LOW;
      SEQ_LOW:  if (byte_done) seq_next = SEQ_HIGH;
      SEQ_HIGH: if (byte_done) seq_next = last_reg ? SEQ_IDLE : SEQ_LOAD;
      default:  seq_next = SEQ_IDLE;
    endcase
  end

  // Sequencer outputs: busy flag, frame start strobes and byte selection.
  always_comb begin
    busy      = (seq != SEQ_IDLE);
    byte_load = (seq == SEQ_LOAD) || (seq == SEQ_LOW && byte_done);
    byte_sel  = (seq == SEQ_HIGH) ? hold[2*BYTE_W-1:BYTE_W] : hold[BYTE_W-1:0];
  end

  // Register address, snapshot of the register value, and completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_addr <= ADDR_FIRST;
      hold    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (seq == SEQ_LOAD) hold <= rf_data;
      if (seq == SEQ_HIGH && byte_done) begin
        if (last_reg) begin
          rf_addr <= ADDR_FIRST;
          done    <= 1'b1;
        end else begin
          rf_addr <= rf_addr + 1'b1;
        end
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .load     (byte_load),
    .byte_in  (byte_sel),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: scoreboard bench for reg_dump. Stimulus pushes expected
// bytes; a monitor decodes frames from tx and compares them.
module tb_reg_dump;

  localparam int CPB = 4;
`ifdef REG_DUMP_PARITY_EN
  localparam int PER_REG  = 89;
  localparam int EXP_BUSY = 445;
`else
  localparam int PER_REG  = 81;
  localparam int EXP_BUSY = 405;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start3;
  logic [3:0]  rf_addr;
  logic [3:0]  rf_addr3;
  logic [15:0] rf_data;
  logic [15:0] rf_data3;
  logic        tx, busy, done;
  logic        tx3, busy3, done3;
  logic [15:0] rf [0:15];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  assign rf_data  = rf[rf_addr];
  assign rf_data3 = rf[rf_addr3];

  reg_dump dut (
    .clk(clk), .reset(reset), .start(start), .rf_addr(rf_addr),
    .rf_data(rf_data), .tx(tx), .busy(busy), .done(done)
  );

  reg_dump #(.FIRST_REG(3), .LAST_REG(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .rf_addr(rf_addr3),
    .rf_data(rf_data3), .tx(tx3), .busy(busy3), .done(done3)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_expected();
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00); exp_q.push_back(8'h80);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
  endtask

  task automatic wait_bits(input int n, output bit aborted);
    aborted = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (reset !== 1'b1) aborted = 1'b1;
    end
  endtask

  // Monitor: decode each frame at mid-bit and compare with the scoreboard.
  initial begin : monitor
    logic [7:0] data;
    logic [7:0] exp_b;
    logic       stop_bit;
    logic       start_bit;
    logic       par_bit;
    bit         ab;
    par_bit = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        wait_bits(CPB / 2, ab);
        start_bit = tx;
        for (int i = 0; i < 8; i++) begin
          if (!ab) wait_bits(CPB, ab);
          data[i] = tx;
        end
`ifdef REG_DUMP_PARITY_EN
        if (!ab) wait_bits(CPB, ab);
        par_bit = tx;
`endif
        if (!ab) wait_bits(CPB, ab);
        stop_bit = tx;
        if (!ab) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_frame: got 0x%0h expected no frame", data);
          end else begin
            exp_b = exp_q.pop_front();
            check_output("frame_byte", {24'h0, data}, {24'h0, exp_b});
            check_output("start_bit", {31'h0, start_bit}, 32'h0);
            check_output("stop_bit", {31'h0, stop_bit}, 32'h1);
`ifdef REG_DUMP_PARITY_EN
            check_output("parity_bit", {31'h0, par_bit}, {31'h0, ^exp_b});
`endif
          end
        end
      end
    end
  end

  // Issue one start pulse and follow the dump until busy drops.
  task automatic apply_stimulus(input bit extra_start, input bit mutate,
                                output int busy_cycles, output int done_in_busy);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    busy_cycles  = 0;
    done_in_busy = 0;
    while (busy === 1'b1 && busy_cycles < 5000) begin
      if (done === 1'b1) done_in_busy++;
      busy_cycles++;
      start = extra_start && (busy_cycles == 10 || busy_cycles == 100);
      if (mutate && busy_cycles == 2 * PER_REG + 20) rf[3] = 16'h1234;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_full_dump(input string tag, input bit extra_start, input bit mutate);
    int bc, dib;
    push_expected();
    apply_stimulus(extra_start, mutate, bc, dib);
    check_output({tag, "_busy_cycles"}, bc, EXP_BUSY);
    check_output({tag, "_done_while_busy"}, dib, 0);
    check_output({tag, "_done_at_end"}, {31'h0, done}, 32'h1);
    @(negedge clk);
    check_output({tag, "_done_one_cycle"}, {31'h0, done}, 32'h0);
    check_output({tag, "_idle_addr"}, {28'h0, rf_addr}, 32'h1);
    check_output({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin : stimulus
    int n;
    reset  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    rf[1] = 16'h0001; rf[2] = 16'h00FF; rf[3] = 16'hA55A;
    rf[4] = 16'h8000; rf[5] = 16'hFFFF;

    repeat (3) @(negedge clk);
    check_output("reset_tx", {31'h0, tx}, 32'h1);
    check_output("reset_busy", {31'h0, busy}, 32'h0);
    check_output("reset_done", {31'h0, done}, 32'h0);
    check_output("reset_addr", {28'h0, rf_addr}, 32'h1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic dump");
    run_full_dump("basic", 1'b0, 1'b0);

    $display("[TB] register changes after load");
    run_full_dump("hold", 1'b0, 1'b1);
    rf[3] = 16'hA55A;

    $display("[TB] start while busy");
    run_full_dump("ignore", 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check_output("ignore_no_second_dump", {31'h0, busy}, 32'h0);

    $display("[TB] reset mid-frame");
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (n < PER_REG + 18) begin
      @(negedge clk);
      n++;
    end
    check_output("abort_addr_before", {28'h0, rf_addr}, 32'h2);
    check_output("abort_busy_before", {31'h0, busy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check_output("abort_tx", {31'h0, tx}, 32'h1);
    check_output("abort_busy", {31'h0, busy}, 32'h0);
    check_output("abort_done", {31'h0, done}, 32'h0);
    check_output("abort_addr", {28'h0, rf_addr}, 32'h1);
    check_output("abort_queue", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    run_full_dump("restart", 1'b0, 1'b0);

    $display("[TB] single register, start held");
    @(negedge clk) start3 = 1'b1;
    @(negedge clk);
    check_output("one_load_busy", {31'h0, busy3}, 32'h1);
    check_output("one_load_addr", {28'h0, rf_addr3}, 32'h3);
    n = 0;
    while (busy3 === 1'b1 && n < 5000) begin
      n++;
      if (n == 2) check_output("one_tx_start", {31'h0, tx3}, 32'h0);
      @(negedge clk);
    end
    check_output("one_busy_cycles", n, PER_REG);
    check_output("one_done", {31'h0, done3}, 32'h1);
    check_output("one_idle_addr", {28'h0, rf_addr3}, 32'h3);
    @(negedge clk);
    check_output("one_back_to_back", {31'h0, busy3}, 32'h1);
    start3 = 1'b0;
    n = 0;
    while (busy3 === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check_output("one_second_busy", n, PER_REG);
    check_output("one_second_done", {31'h0, done3}, 32'h1);
    @(negedge clk);
    check_output("one_stays_idle", {31'h0, busy3}, 32'h0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
